// File: rtl/inta_bus_if.sv
// PIC-side bus bundle for the interrupt-acknowledge master: INT/INTA handshake,
// OCW2 write strobes and the captured vector.
interface inta_bus_if;
    logic       INT;
    logic       int_enable;
    logic [7:0] D_in;
    logic       eoi_req;
    logic       eoi_rotate;
    logic       INTA_n;
    logic       CS_n;
    logic       WR_n;
    logic       A0;
    logic [7:0] D_out;
    logic       D_oe;
    logic [7:0] vector;
    logic       vector_valid;
    logic       busy;

    modport master (
        input  INT, int_enable, D_in, eoi_req, eoi_rotate,
        output INTA_n, CS_n, WR_n, A0, D_out, D_oe, vector, vector_valid, busy
    );

    modport slave (
        output INT, int_enable, D_in, eoi_req, eoi_rotate,
        input  INTA_n, CS_n, WR_n, A0, D_out, D_oe, vector, vector_valid, busy
    );
endinterface

// File: rtl/inta_bus_master.sv
// CPU-side interrupt-acknowledge master: runs the two-pulse INTA sequence to fetch
// a vector from the PIC and issues queued OCW2 end-of-interrupt writes.
module inta_bus_master #(
    parameter int         LOW_CYCLES  = 2,
    parameter int         GAP_CYCLES  = 2,
    parameter logic [7:0] EOI_CMD     = 8'h20,
    parameter logic [7:0] ROT_EOI_CMD = 8'hA0
) (
    input  logic        clk,
    input  logic        reset,
    inta_bus_if.master  bus,
    output logic [2:0]  dbg_state
);

    // Handshake: eoi_req is a one-cycle request with eoi_rotate qualified by it;
    // vector_valid is a one-cycle strobe with vector stable from that cycle on.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INTA1     = 3'd1,
        GAP       = 3'd2,
        INTA2     = 3'd3,
        RECOVER   = 3'd4,
        EOI_SETUP = 3'd5,
        EOI_WR    = 3'd6,
        EOI_HOLD  = 3'd7
    } state_t;

    localparam logic [3:0] LOW_LD = 4'(LOW_CYCLES - 1);
    localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_n;
    logic [3:0] counter;
    logic [3:0] counter_n;

    logic       eoi_pend;
    logic       eoi_rot_q;
    logic       cmd_rot;
    logic       eoi_take;

    logic       inta_n_d;
    logic       cs_n_d;
    logic       wr_n_d;
    logic       d_oe_d;
    logic [7:0] d_out_d;
    logic       busy_d;
    logic       vector_valid_d;
    logic [7:0] vector_d;
    logic       in_eoi;

    assign dbg_state = state;
    assign eoi_take  = (state == IDLE) && eoi_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= 4'd0;
        end else begin
            state   <= state_n;
            counter <= counter_n;
        end
    end

    always_comb begin
        state_n   = state;
        counter_n = counter;
        case (state)
            IDLE: begin
                if (eoi_pend) begin
                    state_n = EOI_SETUP;
                end else if (bus.INT && bus.int_enable) begin
                    state_n   = INTA1;
                    counter_n = LOW_LD;
                end
            end
            INTA1: begin
                if (counter == 4'd0) begin
                    state_n   = GAP;
                    counter_n = GAP_LD;
                end else begin
                    counter_n = counter - 4'd1;
                end
            end
            GAP: begin
                if (counter == 4'd0) begin
                    state_n   = INTA2;
                    counter_n = LOW_LD;
                end else begin
                    counter_n = counter - 4'd1;
                end
            end
            INTA2: begin
                if (counter == 4'd0) begin
                    state_n   = RECOVER;
                    counter_n = GAP_LD;
                end else begin
                    counter_n = counter - 4'd1;
                end
            end
            RECOVER: begin
                if (counter == 4'd0) begin
                    state_n = IDLE;
                end else begin
                    counter_n = counter - 4'd1;
                end
            end
            EOI_SETUP: begin
                state_n   = EOI_WR;
                counter_n = LOW_LD;
            end
            EOI_WR: begin
                if (counter == 4'd0) begin
                    state_n = EOI_HOLD;
                end else begin
                    counter_n = counter - 4'd1;
                end
            end
            EOI_HOLD: begin
                state_n   = IDLE;
                counter_n = 4'd0;
            end
            default: begin
                state_n   = IDLE;
                counter_n = 4'd0;
            end
        endcase
    end

    // Outputs are registered from the current state, so each bus pin trails the
    // state register by one cycle; the vector is captured as INTA_n rises.
    always_comb begin
        in_eoi         = (state == EOI_SETUP) || (state == EOI_WR) || (state == EOI_HOLD);
        inta_n_d       = !((state == INTA1) || (state == INTA2));
        cs_n_d         = !in_eoi;
        wr_n_d         = (state != EOI_WR);
        d_oe_d         = in_eoi;
        d_out_d        = in_eoi ? (cmd_rot ? ROT_EOI_CMD : EOI_CMD) : 8'h00;
        busy_d         = (state != IDLE);
        vector_valid_d = (state == RECOVER) && !bus.INTA_n;
        vector_d       = vector_valid_d ? bus.D_in : bus.vector;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.INTA_n       <= 1'b1;
            bus.CS_n         <= 1'b1;
            bus.WR_n         <= 1'b1;
            bus.A0           <= 1'b0;
            bus.D_out        <= 8'h00;
            bus.D_oe         <= 1'b0;
            bus.vector       <= 8'h00;
            bus.vector_valid <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.INTA_n       <= inta_n_d;
            bus.CS_n         <= cs_n_d;
            bus.WR_n         <= wr_n_d;
            bus.A0           <= 1'b0;
            bus.D_out        <= d_out_d;
            bus.D_oe         <= d_oe_d;
            bus.vector       <= vector_d;
            bus.vector_valid <= vector_valid_d;
            bus.busy         <= busy_d;
        end
    end

    // Single-deep EOI queue; a request landing on the dequeue edge re-arms it.
    // cmd_rot snapshots the flavour being issued so a re-arm cannot alter it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eoi_pend  <= 1'b0;
            eoi_rot_q <= 1'b0;
            cmd_rot   <= 1'b0;
        end else begin
            if (eoi_take) begin
                cmd_rot <= eoi_rot_q;
            end
            if (bus.eoi_req && (!eoi_pend || eoi_take)) begin
                eoi_pend  <= 1'b1;
                eoi_rot_q <= bus.eoi_rotate;
            end else if (eoi_take) begin
                eoi_pend <= 1'b0;
            end
        end
    end

    a_no_strobe_overlap: assert property (@(posedge clk) disable iff (reset)
        !(!bus.INTA_n && !bus.WR_n));

    a_cs_idle_in_inta: assert property (@(posedge clk) disable iff (reset)
        (!bus.INTA_n |-> bus.CS_n));

endmodule

// File: tb/tb_inta_bus_master.sv
// Bench for inta_bus_master: directed timing checks plus randomized INTA/EOI
// traffic scored against a queue of expected vectors and OCW2 bytes.
module tb_inta_bus_master;

    localparam int LOW = 2;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] dbg_state;

    inta_bus_if bus();

    inta_bus_master #(
        .LOW_CYCLES (LOW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];
    logic [7:0] cur_vec = 8'h00;
    int         pulse_cnt = 0;
    logic       prev_inta = 1'b1;
    logic       prev_wr = 1'b1;

    // Expected-item encoding: bit 8 = 1 for an OCW2 write, 0 for a vector fetch.
    function automatic logic [8:0] vec_item(input logic [7:0] v);
        return {1'b0, v};
    endfunction

    function automatic logic [8:0] eoi_item(input logic rot);
        return {1'b1, (rot ? 8'hA0 : 8'h20)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PIC model: junk on the first INTA pulse, the pending vector on the second.
    always @(negedge clk) begin
        if (reset) begin
            pulse_cnt = 0;
            prev_inta = 1'b1;
            bus.D_in  = 8'h00;
        end else begin
            if (prev_inta && !bus.INTA_n) begin
                pulse_cnt++;
                bus.D_in = pulse_cnt[0] ? ~cur_vec : cur_vec;
            end
            prev_inta = bus.INTA_n;
        end
    end

    // Monitor: pops an expectation on each vector strobe and each WR_n fall.
    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            prev_wr = 1'b1;
        end else begin
            if (bus.vector_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_vector: got %0h, expected no transaction", bus.vector);
                end else begin
                    e = exp_q.pop_front();
                    check("vector", {23'd0, 1'b0, bus.vector}, {23'd0, e});
                end
            end
            if (prev_wr && !bus.WR_n) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_eoi: got %0h, expected no transaction", bus.D_out);
                end else begin
                    e = exp_q.pop_front();
                    check("eoi_cmd", {23'd0, 1'b1, bus.D_out}, {23'd0, e});
                    check("eoi_cs_n", 32'(bus.CS_n), 32'd0);
                    check("eoi_a0", 32'(bus.A0), 32'd0);
                    check("eoi_d_oe", 32'(bus.D_oe), 32'd1);
                end
            end
            if (!bus.INTA_n || !bus.WR_n) begin
                check("strobe_overlap", 32'(!bus.INTA_n && !bus.WR_n), 32'd0);
            end
            if (!bus.INTA_n) begin
                check("cs_during_inta", 32'(bus.CS_n), 32'd1);
            end
            prev_wr = bus.WR_n;
        end
    end

    task automatic wait_inta(input logic lvl);
        for (int i = 0; i < 60; i++) begin
            if (bus.INTA_n === lvl) return;
            @(negedge clk);
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_inta: got timeout, expected INTA_n=%0b", lvl);
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            if (bus.busy === 1'b0) quiet++;
            else quiet = 0;
            if (quiet >= 4) return;
            @(negedge clk);
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_idle: got busy timeout, expected return to idle");
    endtask

    task automatic pulse_eoi(input logic rot);
        bus.eoi_rotate = rot;
        bus.eoi_req    = 1'b1;
        @(negedge clk);
        bus.eoi_req    = 1'b0;
        bus.eoi_rotate = 1'($urandom_range(0, 1));
    endtask

    task automatic do_int(input logic [7:0] v);
        cur_vec = v;
        exp_q.push_back(vec_item(v));
        bus.int_enable = 1'b1;
        bus.INT        = 1'b1;
        wait_inta(1'b0);
        bus.INT = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_inta_n"}, 32'(bus.INTA_n), 32'd1);
        check({tag, "_cs_n"}, 32'(bus.CS_n), 32'd1);
        check({tag, "_wr_n"}, 32'(bus.WR_n), 32'd1);
        check({tag, "_a0"}, 32'(bus.A0), 32'd0);
        check({tag, "_d_out"}, 32'(bus.D_out), 32'd0);
        check({tag, "_d_oe"}, 32'(bus.D_oe), 32'd0);
        check({tag, "_vector"}, 32'(bus.vector), 32'd0);
        check({tag, "_vector_valid"}, 32'(bus.vector_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got no completion, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        logic r1;
        logic r2;
        logic [7:0] v;
        int   j;

        bus.INT        = 1'b0;
        bus.int_enable = 1'b0;
        bus.eoi_req    = 1'b0;
        bus.eoi_rotate = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed INTA sequence timing, k counts edges after the sampling edge E.
        cur_vec = 8'h4A;
        exp_q.push_back(vec_item(8'h4A));
        bus.int_enable = 1'b1;
        bus.INT        = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.INT = 1'b0;
            check($sformatf("t1_inta_n_k%0d", k), 32'(bus.INTA_n),
                  32'(!((k >= 1 && k <= LOW) || (k >= LOW + GAP + 1 && k <= 2 * LOW + GAP))));
            check($sformatf("t1_vvalid_k%0d", k), 32'(bus.vector_valid),
                  32'(k == 2 * LOW + GAP + 1));
            check($sformatf("t1_busy_k%0d", k), 32'(bus.busy),
                  32'(k >= 1 && k <= 2 * LOW + 2 * GAP));
        end
        check("t1_vector_held", 32'(bus.vector), 32'h4A);
        wait_idle();

        // INT masked by int_enable, then released.
        bus.int_enable = 1'b0;
        bus.INT        = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t2_masked_inta_n", 32'(bus.INTA_n), 32'd1);
            check("t2_masked_busy", 32'(bus.busy), 32'd0);
        end
        cur_vec = 8'h5C;
        exp_q.push_back(vec_item(8'h5C));
        bus.int_enable = 1'b1;
        repeat (2) @(negedge clk);
        check("t2_enable_start", 32'(bus.INTA_n), 32'd0);
        bus.INT = 1'b0;
        wait_idle();

        // Directed non-rotating EOI write timing.
        exp_q.push_back(eoi_item(1'b0));
        bus.eoi_rotate = 1'b0;
        bus.eoi_req    = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            bus.eoi_req = 1'b0;
            check($sformatf("t3_cs_n_k%0d", k), 32'(bus.CS_n), 32'(!(k >= 2 && k <= 5)));
            check($sformatf("t3_wr_n_k%0d", k), 32'(bus.WR_n), 32'(!(k >= 3 && k <= 2 + LOW)));
            check($sformatf("t3_d_out_k%0d", k), 32'(bus.D_out), (k >= 2 && k <= 5) ? 32'h20 : 32'h0);
            check($sformatf("t3_d_oe_k%0d", k), 32'(bus.D_oe), 32'(k >= 2 && k <= 5));
        end
        wait_idle();

        // Rotating EOI requested mid-sequence, second request must be dropped.
        do_int(8'h91);
        wait_inta(1'b1);
        wait_inta(1'b0);
        pulse_eoi(1'b1);
        pulse_eoi(1'b0);
        exp_q.push_back(eoi_item(1'b1));
        wait_idle();

        // Pending EOI beats a simultaneous INT.
        pulse_eoi(1'b0);
        exp_q.push_back(eoi_item(1'b0));
        cur_vec = 8'h27;
        exp_q.push_back(vec_item(8'h27));
        bus.int_enable = 1'b1;
        bus.INT        = 1'b1;
        wait_inta(1'b0);
        bus.INT = 1'b0;
        wait_idle();
        check("t5_vector", 32'(bus.vector), 32'h27);

        // Reset in the middle of the second INTA pulse, with an EOI pending.
        do_int(8'hC3);
        pulse_eoi(1'b1);
        wait_inta(1'b1);
        wait_inta(1'b0);
        reset = 1'b1;
        #1;
        check_reset_values("t6_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_int(8'h3E);
        wait_idle();
        check("t6_fresh_vector", 32'(bus.vector), 32'h3E);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            v  = 8'($urandom_range(0, 255));
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            j  = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0: do_int(v);
                1: begin
                    exp_q.push_back(eoi_item(r1));
                    pulse_eoi(r1);
                end
                2: begin
                    do_int(v);
                    repeat (j) @(negedge clk);
                    pulse_eoi(r1);
                    pulse_eoi(r2);
                    exp_q.push_back(eoi_item(r1));
                end
                default: begin
                    pulse_eoi(r1);
                    exp_q.push_back(eoi_item(r1));
                    cur_vec = v;
                    exp_q.push_back(vec_item(v));
                    bus.int_enable = 1'b1;
                    bus.INT        = 1'b1;
                    wait_inta(1'b0);
                    bus.INT = 1'b0;
                end
            endcase
            wait_idle();
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
